// File: rtl/discrete_sizes_pkg.sv
// Shared types and sizing helpers for the discrete sizes table loader.
// Optional feature macro: DISCRETE_SIZES_LOAD_CHECKSUM_EN (trailing XOR checksum word per load).
package discrete_sizes_pkg;

    // Loader FSM; StCheck is only reachable when the checksum feature is built in.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } load_state_e;

    // Table depth for a given variable index width.
    function automatic int unsigned num_entries(input int unsigned idx_width);
        return 32'd1 << idx_width;
    endfunction

    // The checksum is a running XOR of entries, so it is exactly one entry wide.
    function automatic int unsigned checksum_width(input int unsigned cho_width);
        return cho_width;
    endfunction

endpackage

// File: rtl/discrete_sizes_ram.sv
// Table storage: one write port, one registered read-before-write read port.
// Storage is never reset so it can map onto RAM; only the read data register is cleared.
module discrete_sizes_ram
    import discrete_sizes_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_write_address,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_read_address,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    localparam int unsigned DEPTH = num_entries(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;

    // Write port; no reset so the array stays RAM-inferable.
    always_ff @(posedge i_clock) begin
        if (i_write_enable) begin
            r_mem[i_write_address] <= i_write_data;
        end
    end

    // Registered read; sees the pre-write contents on a same-address collision.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_read_data <= '0;
        end else begin
            r_read_data <= r_mem[i_read_address];
        end
    end

    assign o_read_data = r_read_data;

endmodule

// File: rtl/discrete_sizes_loader.sv
// Runtime loader and holder of the per-variable max inside-choice index table.
// Host streams NUM_ENTRIES words over valid/ready after a start pulse; randomizer reads through
// a 1-cycle registered port and waits for out_table_valid.
// Optional feature macro: DISCRETE_SIZES_LOAD_CHECKSUM_EN adds a trailing XOR checksum word.
module discrete_sizes_loader
    import discrete_sizes_pkg::*;
#(
    parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
    parameter int unsigned MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 2
) (
    input  logic                                         in_clock,
    input  logic                                         in_reset,
    input  logic                                         in_load_start,
    input  logic                                         in_data_valid,
    input  logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] in_data,
    output logic                                         out_data_ready,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_variable_index,
    output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] out_number_of_discrete_assignments,
    output logic                                         out_table_valid,
    output logic                                         out_busy,
    output logic                                         out_load_error
);

    localparam int unsigned IDX         = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int unsigned CHO         = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
    localparam int unsigned NUM_ENTRIES = num_entries(IDX);
    // One extra bit so the counter can never wrap inside a load.
    localparam int unsigned CNT_W       = IDX + 1;
    localparam logic [CNT_W-1:0] LAST_INDEX = CNT_W'(NUM_ENTRIES - 1);

    load_state_e      r_state;
    load_state_e      w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_table_valid;
    logic             w_table_valid_next;
    logic             w_write_enable;
    logic             w_load_error;

`ifdef DISCRETE_SIZES_LOAD_CHECKSUM_EN
    localparam int unsigned CKS_W = checksum_width(CHO);

    logic [CKS_W-1:0] r_checksum;
    logic [CKS_W-1:0] w_checksum_next;
    logic             r_load_error;
    logic             w_load_error_next;

    assign w_load_error = r_load_error;
`else
    assign w_load_error = 1'b0;
`endif

    // Next-state logic; a start pulse overrides everything and discards any same-cycle word.
    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_table_valid_next = r_table_valid;
        w_write_enable     = 1'b0;
`ifdef DISCRETE_SIZES_LOAD_CHECKSUM_EN
        w_checksum_next    = r_checksum;
        w_load_error_next  = r_load_error;
`endif
        if (in_load_start) begin
            w_state_next       = StLoad;
            w_count_next       = '0;
            w_table_valid_next = 1'b0;
`ifdef DISCRETE_SIZES_LOAD_CHECKSUM_EN
            w_checksum_next    = '0;
            w_load_error_next  = 1'b0;
`endif
        end else begin
            case (r_state)
                StLoad: begin
                    if (in_data_valid) begin
                        w_write_enable = 1'b1;
                        w_count_next   = r_count + CNT_W'(1);
`ifdef DISCRETE_SIZES_LOAD_CHECKSUM_EN
                        w_checksum_next = r_checksum ^ in_data;
                        if (r_count == LAST_INDEX) begin
                            w_state_next = StCheck;
                        end
`else
                        if (r_count == LAST_INDEX) begin
                            w_state_next = StDone;
                        end
`endif
                    end
                end
`ifdef DISCRETE_SIZES_LOAD_CHECKSUM_EN
                StCheck: begin
                    if (in_data_valid) begin
                        w_load_error_next = (in_data != r_checksum);
                        w_state_next      = StDone;
                    end
                end
`endif
                StDone: begin
                    w_table_valid_next = ~w_load_error;
                    w_state_next       = StIdle;
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // Handshake and busy are purely a function of the current state.
    always_comb begin
        out_data_ready = (r_state == StLoad) || (r_state == StCheck);
        out_busy       = out_data_ready;
    end

    // State, counter and flag registers.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_state       <= StIdle;
            r_count       <= '0;
            r_table_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_table_valid <= w_table_valid_next;
        end
    end

`ifdef DISCRETE_SIZES_LOAD_CHECKSUM_EN
    // Running checksum and sticky mismatch flag.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_checksum   <= '0;
            r_load_error <= 1'b0;
        end else begin
            r_checksum   <= w_checksum_next;
            r_load_error <= w_load_error_next;
        end
    end
`endif

    assign out_table_valid = r_table_valid;
    assign out_load_error  = w_load_error;

    discrete_sizes_ram #(
        .ADDR_WIDTH (IDX),
        .DATA_WIDTH (CHO)
    ) u_ram (
        .i_clock         (in_clock),
        .i_reset         (in_reset),
        .i_write_enable  (w_write_enable),
        .i_write_address (r_count[IDX-1:0]),
        .i_write_data    (in_data),
        .i_read_address  (in_variable_index),
        .o_read_data     (out_number_of_discrete_assignments)
    );

endmodule
